stopwatch_timer: RTL and testbench

STOPWATCH_TIMER -- requirements
Module: stopwatch_timer

---
 rtl/stopwatch_if.sv | 31 +++
 rtl/stopwatch_timer.sv | 163 ++++++++++++++++
 tb/tb_stopwatch_timer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// Control/status bundle for stopwatch_timer; master drives controls, slave owns the count outputs.
interface stopwatch_if #(
    parameter int unsigned HR_W = 5
);
    localparam int unsigned CW = HR_W + 12;

    logic          tick;
    logic          start;
    logic          stop;
    logic          clear;
    logic          mode;
    logic          load;
    logic [CW-1:0] load_val;
    logic          lap;
    logic [CW-1:0] time_out;
    logic          running;
    logic          expired;
    logic          overflow;
    logic [CW-1:0] lap_out;
    logic          lap_valid;

    modport master (
        output tick, start, stop, clear, mode, load, load_val, lap,
        input  time_out, running, expired, overflow, lap_out, lap_valid
    );

    modport slave (
        input  tick, start, stop, clear, mode, load, load_val, lap,
        output time_out, running, expired, overflow, lap_out, lap_valid
    );
endinterface

// File: rtl/stopwatch_timer.sv
// Up/down hh:mm:ss stopwatch with IDLE/RUN/PAUSE/DONE control and saturating terminal count.
// Lap capture is built only when STOPWATCH_LAP_CAPTURE_EN is defined.
module stopwatch_timer #(
    parameter int unsigned SEC_MAX = 59,
    parameter int unsigned MIN_MAX = 59,
    parameter int unsigned HR_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    stopwatch_if.slave  bus
);
    localparam int unsigned CW = HR_W + 12;
    localparam logic [5:0]      SEC_TOP = 6'(SEC_MAX);
    localparam logic [5:0]      MIN_TOP = 6'(MIN_MAX);
    localparam logic [HR_W-1:0] HR_TOP  = '1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    typedef struct packed {
        logic [HR_W-1:0] hr;
        logic [5:0]      min;
        logic [5:0]      sec;
    } cnt_t;

    state_t state_q, state_n;
    cnt_t   cnt_q, cnt_n, cnt_inc, cnt_dec, cnt_ld;
    logic   mode_q, mode_n, down_eff;
    logic   expired_q, expired_n;
    logic   overflow_q, overflow_n;
    logic   running_q;
    logic   cnt_is_zero, cnt_is_top;

    assign cnt_is_zero = (cnt_q == '0);
    assign cnt_is_top  = (cnt_q.hr == HR_TOP) && (cnt_q.min == MIN_TOP) && (cnt_q.sec == SEC_TOP);

    // Next-count candidates: one step up, one step down, and the clamped preset
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q.sec == SEC_TOP) begin
            cnt_inc.sec = '0;
            if (cnt_q.min == MIN_TOP) begin
                cnt_inc.min = '0;
                cnt_inc.hr  = cnt_q.hr + HR_W'(1);
            end else begin
                cnt_inc.min = cnt_q.min + 6'd1;
            end
        end else begin
            cnt_inc.sec = cnt_q.sec + 6'd1;
        end

        cnt_dec = cnt_q;
        if (cnt_q.sec == 6'd0) begin
            cnt_dec.sec = SEC_TOP;
            if (cnt_q.min == 6'd0) begin
                cnt_dec.min = MIN_TOP;
                cnt_dec.hr  = cnt_q.hr - HR_W'(1);
            end else begin
                cnt_dec.min = cnt_q.min - 6'd1;
            end
        end else begin
            cnt_dec.sec = cnt_q.sec - 6'd1;
        end

        cnt_ld.hr  = bus.load_val[CW-1:12];
        cnt_ld.min = (bus.load_val[11:6] > MIN_TOP) ? MIN_TOP : bus.load_val[11:6];
        cnt_ld.sec = (bus.load_val[5:0]  > SEC_TOP) ? SEC_TOP : bus.load_val[5:0];
    end

    // Control: clear > load > stop > start > tick; a stop pulse always masks start
    always_comb begin
        state_n    = state_q;
        cnt_n      = cnt_q;
        mode_n     = mode_q;
        expired_n  = expired_q;
        overflow_n = overflow_q;
        down_eff   = mode_q;

        if (bus.clear) begin
            state_n    = IDLE;
            cnt_n      = '0;
            expired_n  = 1'b0;
            overflow_n = 1'b0;
        end else if (bus.load && (state_q == IDLE || state_q == PAUSE)) begin
            cnt_n = cnt_ld;
        end else if (bus.stop) begin
            if (state_q == RUN) state_n = PAUSE;
        end else if (bus.start && (state_q == IDLE || state_q == PAUSE)) begin
            if (state_q == IDLE) begin
                mode_n   = bus.mode;
                down_eff = bus.mode;
            end
            if (down_eff && cnt_is_zero) begin
                state_n   = DONE;
                expired_n = 1'b1;
            end else begin
                state_n = RUN;
            end
        end else if (bus.tick && state_q == RUN) begin
            if (!mode_q) begin
                if (cnt_is_top) begin
                    state_n    = DONE;
                    overflow_n = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end else begin
                cnt_n = cnt_dec;
                if (cnt_dec == '0) begin
                    state_n   = DONE;
                    expired_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            expired_q  <= 1'b0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            mode_q     <= mode_n;
            expired_q  <= expired_n;
            overflow_q <= overflow_n;
            running_q  <= (state_n == RUN);
        end
    end

    assign bus.time_out = cnt_q;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.overflow = overflow_q;

`ifdef STOPWATCH_LAP_CAPTURE_EN
    cnt_t lap_q;
    logic lap_valid_q;
    logic lap_take;

    // Capture uses the pre-tick count held in cnt_q
    assign lap_take = bus.lap && (state_q == RUN || state_q == PAUSE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_valid_q <= lap_take;
            if (lap_take) lap_q <= cnt_q;
        end
    end

    assign bus.lap_out   = lap_q;
    assign bus.lap_valid = lap_valid_q;
`else
    assign bus.lap_out   = '0;
    assign bus.lap_valid = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_timer.sv
// Bench for stopwatch_timer: directed scenarios plus random control traffic against a
// total-seconds reference model; a second HR_W=1 instance covers up-count saturation.
module tb_stopwatch_timer;
    localparam int SM     = 59;
    localparam int MM     = 59;
    localparam int HW     = 5;
    localparam int PER    = (MM + 1) * (SM + 1);
    localparam int TOTMAX = (1 << HW) * PER - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clk;
    logic rst;

    stopwatch_if #(.HR_W(HW)) b ();
    stopwatch_if #(.HR_W(1))  b1 ();

    stopwatch_timer #(.SEC_MAX(SM), .MIN_MAX(MM), .HR_W(HW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    stopwatch_timer #(.SEC_MAX(SM), .MIN_MAX(MM), .HR_W(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the count is a single number of elapsed seconds
    int m_st, m_total, m_lap;
    bit m_down, m_exp, m_ovf, m_lapv;

    function automatic logic [16:0] to_fields(int t);
        return {5'(t / PER), 6'((t % PER) / (SM + 1)), 6'(t % (SM + 1))};
    endfunction

    function automatic int from_load(logic [16:0] v);
        int h, m, s;
        h = int'(v[16:12]);
        m = int'(v[11:6]);
        s = int'(v[5:0]);
        if (m > MM) m = MM;
        if (s > SM) s = SM;
        return h * PER + m * (SM + 1) + s;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_total = 0; m_lap = 0;
        m_down = 0; m_exp = 0; m_ovf = 0; m_lapv = 0;
    endtask

    task automatic model_apply();
        m_lapv = 0;
`ifdef STOPWATCH_LAP_CAPTURE_EN
        if (b.lap && (m_st == M_RUN || m_st == M_PAUSE)) begin
            m_lap  = m_total;
            m_lapv = 1;
        end
`endif
        if (b.clear) begin
            m_st = M_IDLE; m_total = 0; m_exp = 0; m_ovf = 0;
        end else if (b.load && (m_st == M_IDLE || m_st == M_PAUSE)) begin
            m_total = from_load(b.load_val);
        end else if (b.stop) begin
            if (m_st == M_RUN) m_st = M_PAUSE;
        end else if (b.start && (m_st == M_IDLE || m_st == M_PAUSE)) begin
            if (m_st == M_IDLE) m_down = b.mode;
            if (m_down && m_total == 0) begin
                m_st = M_DONE; m_exp = 1;
            end else begin
                m_st = M_RUN;
            end
        end else if (b.tick && m_st == M_RUN) begin
            if (!m_down) begin
                if (m_total == TOTMAX) begin
                    m_st = M_DONE; m_ovf = 1;
                end else begin
                    m_total++;
                end
            end else begin
                m_total--;
                if (m_total == 0) begin
                    m_st = M_DONE; m_exp = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("time_out",  32'(b.time_out), 32'(to_fields(m_total)));
        chk("running",   32'(b.running),  32'(m_st == M_RUN));
        chk("expired",   32'(b.expired),  32'(m_exp));
        chk("overflow",  32'(b.overflow), 32'(m_ovf));
        chk("lap_out",   32'(b.lap_out),  32'(to_fields(m_lap)));
        chk("lap_valid", 32'(b.lap_valid), 32'(m_lapv));
    endtask

    task automatic clear_pulses();
        b.tick = 0; b.start = 0; b.stop = 0; b.clear = 0; b.load = 0; b.lap = 0;
        b1.tick = 0; b1.start = 0; b1.stop = 0; b1.clear = 0; b1.load = 0; b1.lap = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_apply();
        #1;
        clear_pulses();
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            b.tick = 1;
            step();
        end
    endtask

    initial begin
        logic [16:0] e;
        logic [12:0] e1;

        rst = 1;
        clear_pulses();
        b.mode = 0; b.load_val = '0;
        b1.mode = 0; b1.load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_time1", 32'(b1.time_out), 32'd0);
        rst = 0;

        // Up count across the minute and hour carries
        b.start = 1; step();
        ticks(60);
        e = {5'd0, 6'd1, 6'd0};
        chk("up_1min", 32'(b.time_out), 32'(e));
        ticks(3540);
        e = {5'd1, 6'd0, 6'd0};
        chk("up_1hr", 32'(b.time_out), 32'(e));

        // Pause/resume and clamped load
        b.clear = 1; step();
        b.start = 1; step();
        ticks(5);
        b.stop = 1; step();
        ticks(10);
        b.start = 1; step();
        ticks(2);
        e = {5'd0, 6'd0, 6'd7};
        chk("pause_sec7", 32'(b.time_out), 32'(e));
        b.stop = 1; step();
        b.load_val = {5'd0, 6'd0, 6'd63}; b.load = 1; step();
        e = {5'd0, 6'd0, 6'd59};
        chk("clamp_sec", 32'(b.time_out), 32'(e));
        b.load_val = {5'd2, 6'd60, 6'd10}; b.load = 1; step();
        e = {5'd2, 6'd59, 6'd10};
        chk("clamp_min", 32'(b.time_out), 32'(e));
        b.tick = 1; b.start = 1; b.stop = 1; step();
        chk("stop_beats_start", 32'(b.running), 32'd0);

        // Down count to expiry, then clear
        b.clear = 1; step();
        b.load_val = {5'd0, 6'd1, 6'd0}; b.load = 1; step();
        b.mode = 1; b.start = 1; step();
        b.mode = 0;
        ticks(1);
        e = {5'd0, 6'd0, 6'd59};
        chk("down_borrow", 32'(b.time_out), 32'(e));
        ticks(59);
        chk("down_zero", 32'(b.time_out), 32'd0);
        chk("down_expired", 32'(b.expired), 32'd1);
        ticks(3);
        b.start = 1; step();
        chk("done_hold", 32'(b.expired), 32'd1);
        b.clear = 1; step();
        chk("clear_expired", 32'(b.expired), 32'd0);

        // Down start from zero goes straight to DONE
        b.mode = 1; b.start = 1; step();
        b.mode = 0;
        chk("down_zero_start", 32'(b.expired), 32'd1);
        chk("down_zero_run", 32'(b.running), 32'd0);
        b.clear = 1; step();

        // Lap with a same-cycle tick
        b.start = 1; step();
        ticks(4);
        b.lap = 1; b.tick = 1; step();
        e = {5'd0, 6'd0, 6'd5};
        chk("lap_time", 32'(b.time_out), 32'(e));
`ifdef STOPWATCH_LAP_CAPTURE_EN
        e = {5'd0, 6'd0, 6'd4};
        chk("lap_out", 32'(b.lap_out), 32'(e));
        chk("lap_valid_hi", 32'(b.lap_valid), 32'd1);
`else
        chk("lap_out_tied", 32'(b.lap_out), 32'd0);
        chk("lap_valid_tied", 32'(b.lap_valid), 32'd0);
`endif
        step();
        chk("lap_valid_lo", 32'(b.lap_valid), 32'd0);

        // Up-count saturation at the top of a 5-bit hour field
        b.clear = 1; step();
        b.load_val = {5'd31, 6'd59, 6'd57}; b.load = 1; step();
        b.start = 1; step();
        ticks(5);
        e = {5'd31, 6'd59, 6'd59};
        chk("sat_hold", 32'(b.time_out), 32'(e));
        chk("sat_overflow", 32'(b.overflow), 32'd1);
        b.clear = 1; step();

        // Random control traffic against the model
        for (int i = 0; i < 1500; i++) begin
            b.tick     = ($urandom_range(0, 99) < 70);
            b.start    = ($urandom_range(0, 99) < 8);
            b.stop     = ($urandom_range(0, 99) < 4);
            b.clear    = ($urandom_range(0, 99) < 2);
            b.load     = ($urandom_range(0, 99) < 4);
            b.lap      = ($urandom_range(0, 99) < 10);
            b.mode     = 1'($urandom_range(0, 1));
            b.load_val = 17'($urandom);
            step();
        end
        b.mode = 0;

        // Async reset between edges at {0,3,12}
        b.clear = 1; step();
        b.load_val = {5'd0, 6'd3, 6'd12}; b.load = 1; step();
        b.start = 1; step();
        e = {5'd0, 6'd3, 6'd12};
        chk("pre_rst", 32'(b.time_out), 32'(e));
        #3 rst = 1;
        #1;
        chk("async_rst_time", 32'(b.time_out), 32'd0);
        chk("async_rst_run", 32'(b.running), 32'd0);
        model_reset();
        #1 rst = 0;
        b.start = 1; step();
        ticks(2);

        // HR_W=1 instance: saturate at {1,59,59}
        b1.load_val = {1'b1, 6'd59, 6'd58}; b1.load = 1; step();
        b1.start = 1; step();
        chk("h1_running", 32'(b1.running), 32'd1);
        b1.tick = 1; step();
        e1 = {1'b1, 6'd59, 6'd59};
        chk("h1_top", 32'(b1.time_out), 32'(e1));
        chk("h1_no_ovf_yet", 32'(b1.overflow), 32'd0);
        b1.tick = 1; step();
        chk("h1_held", 32'(b1.time_out), 32'(e1));
        chk("h1_overflow", 32'(b1.overflow), 32'd1);
        chk("h1_stopped", 32'(b1.running), 32'd0);
        for (int i = 0; i < 3; i++) begin
            b1.tick = 1; step();
        end
        chk("h1_still_held", 32'(b1.time_out), 32'(e1));
        chk("h1_still_ovf", 32'(b1.overflow), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
